// File: rtl/lvt_multiport_ram_if.sv
// Port bundle for lvt_multiport_ram: NW flat write ports, NR flat read ports, status.
interface lvt_multiport_ram_if #(
  parameter int DW = 32,
  parameter int AW = 11,
  parameter int NR = 8,
  parameter int NW = 2
);
  logic [NW-1:0]    w_en;
  logic [NW*AW-1:0] w_addr;
  logic [NW*DW-1:0] w_din;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_dout;
  logic             ready;
  logic             w_conflict;

  modport master (
    output w_en, w_addr, w_din, r_addr,
    input  r_dout, ready, w_conflict
  );

  modport slave (
    input  w_en, w_addr, w_din, r_addr,
    output r_dout, ready, w_conflict
  );
endinterface

// File: rtl/lvt_multiport_ram.sv
// NW-write / NR-read RAM: per-read-port lanes of NW replicated banks, steered by a
// live-value table; self-clearing init sweep, write-conflict arbitration, optional bypass.
module lvt_lane #(
  parameter int DW     = 32,
  parameter int AW     = 11,
  parameter int NW     = 2,
  parameter int LW     = 1,
  parameter int BYPASS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [NW-1:0]          we,
  input  logic [NW-1:0][AW-1:0]  wa,
  input  logic [NW-1:0][DW-1:0]  wd,
  input  logic [AW-1:0]          init_addr,
  input  logic [AW-1:0]          ra,
  input  logic [LW-1:0]          sel,
  output logic [DW-1:0]          dout
);
  localparam int DEPTH = 2**AW;

  logic [NW-1:0][DW-1:0] bank_rd;
  logic                  hit;
  logic [DW-1:0]         fwd;

  // One bank per write port; the init sweep owns every bank until RUN.
  for (genvar k = 0; k < NW; k++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (!run)
        mem[init_addr] <= '0;
      else if (we[k])
        mem[wa[k]] <= wd[k];
    end
    assign bank_rd[k] = mem[ra];
  end

  // we[] carries only arbitration winners, so at most one port can hit ra.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < NW; k++) begin
      if (we[k] && wa[k] == ra) begin
        hit = 1'b1;
        fwd = wd[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run)
      dout <= '0;
    else if (BYPASS != 0 && hit)
      dout <= fwd;
    else
      dout <= bank_rd[sel];
  end
endmodule

module lvt_multiport_ram #(
  parameter int DW     = 32,
  parameter int AW     = 11,
  parameter int NR     = 8,
  parameter int NW     = 2,
  parameter int BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  lvt_multiport_ram_if.slave    bus
);
  localparam int DEPTH = 2**AW;
  localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}})
          state_d = RUN;
      end
      default: ;
    endcase
  end

  assign run       = (state_q == RUN);
  assign bus.ready = run;

  logic [NW-1:0][AW-1:0] wa;
  logic [NW-1:0][DW-1:0] wd;
  logic [NR-1:0][AW-1:0] ra;
  logic [NR-1:0][DW-1:0] rd;
  logic [NR-1:0][LW-1:0] lvt_rd;

  for (genvar k = 0; k < NW; k++) begin : g_wport
    assign wa[k] = bus.w_addr[k*AW +: AW];
    assign wd[k] = bus.w_din[k*DW +: DW];
  end

  for (genvar j = 0; j < NR; j++) begin : g_rport
    assign ra[j]                   = bus.r_addr[j*AW +: AW];
    assign bus.r_dout[j*DW +: DW]  = rd[j];
  end

  // A port loses if any higher-index enabled port targets the same address.
  logic [NW-1:0] win, we_win;
  logic          conflict, w_conflict_q;

  always_comb begin
    win = '0;
    for (int k = 0; k < NW; k++) begin
      win[k] = bus.w_en[k];
      for (int m = k + 1; m < NW; m++)
        if (bus.w_en[m] && wa[m] == wa[k])
          win[k] = 1'b0;
    end
  end

  assign we_win   = (run && !rst) ? win : '0;
  assign conflict = run && |(bus.w_en & ~win);

  always_ff @(posedge clk) begin
    if (rst)
      w_conflict_q <= 1'b0;
    else
      w_conflict_q <= conflict;
  end
  assign bus.w_conflict = w_conflict_q;

  if (NW > 1) begin : g_lvt
    logic [LW-1:0] lvt [DEPTH];
    always_ff @(posedge clk) begin
      if (!run)
        lvt[cnt_q] <= '0;
      else
        for (int k = 0; k < NW; k++)
          if (we_win[k])
            lvt[wa[k]] <= LW'(k);
    end
    for (genvar j = 0; j < NR; j++) begin : g_rd
      assign lvt_rd[j] = lvt[ra[j]];
    end
  end else begin : g_nolvt
    assign lvt_rd = '0;
  end

  for (genvar j = 0; j < NR; j++) begin : g_lane
    lvt_lane #(
      .DW(DW), .AW(AW), .NW(NW), .LW(LW), .BYPASS(BYPASS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .we        (we_win),
      .wa        (wa),
      .wd        (wd),
      .init_addr (cnt_q),
      .ra        (ra[j]),
      .sel       (lvt_rd[j]),
      .dout      (rd[j])
    );
  end
endmodule
